// File: rtl/d_pkg.sv
// Shared constants and channel encodings for the 1-to-4 result distributor.
package d_pkg;
  localparam int unsigned W     = 16;
  localparam int unsigned N_CH  = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned SW    = $clog2(N_CH);

  typedef enum logic [1:0] {
    CH_RF  = 2'd0,
    CH_PC  = 2'd1,
    CH_MDR = 2'd2,
    CH_IO  = 2'd3
  } ch_e;
endpackage

// File: rtl/fifo_ch.sv
// Single-clock per-channel FIFO; head word is always presented on dout.
module fifo_ch #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Self-protecting: a push while full or a pop while empty is dropped.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head is only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/d1_4_dist.sv
// 1-to-4 result distributor: routes each accepted word by S into a per-channel FIFO.
module d1_4_dist
  import d_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [W-1:0]    I,
  input  logic [SW-1:0]   S,
  input  logic            IV,
  output logic            IR,
  output logic [W-1:0]    O0,
  output logic [W-1:0]    O1,
  output logic [W-1:0]    O2,
  output logic [W-1:0]    O3,
  output logic [N_CH-1:0] OV,
  input  logic [N_CH-1:0] OR
);
  logic [N_CH-1:0] full;
  logic [N_CH-1:0] empty;
  logic [N_CH-1:0] push_en;
  logic [N_CH-1:0] pop_en;
  logic [W-1:0]    head [N_CH];

  // Ready follows only the selected channel's full flag; a same-cycle pop does not help.
  assign IR     = ~full[S];
  assign OV     = ~empty;
  assign pop_en = OR & OV;

  for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
    assign push_en[k] = IV & IR & (S == SW'(k));

    fifo_ch #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (push_en[k]),
      .din   (I),
      .pop   (pop_en[k]),
      .dout  (head[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  // Empty channels present zero so consumers never see stale words.
  assign O0 = OV[0] ? head[0] : '0;
  assign O1 = OV[1] ? head[1] : '0;
  assign O2 = OV[2] ? head[2] : '0;
  assign O3 = OV[3] ? head[3] : '0;
endmodule
